// File: rtl/dff_checker.sv
// Self-checking monitor for a D flip-flop with synchronous active-high reset.
// Optional macro DFF_CHK_QN_EN adds a qn == ~q complement check to every compare.
module dff_checker #(
  parameter int CHK_LEN = 16,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_rst,
  input  logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [15:0]      first_err_idx
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // CHECK | one compare per edge, CHK_LEN compares in total
  // DONE  | results held until the next start
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

`ifdef DFF_CHK_QN_EN
  localparam bit QN_EN = 1'b1;
`else
  localparam bit QN_EN = 1'b0;
`endif

  localparam logic [15:0] LAST = 16'(CHK_LEN - 1);

  state_t           state;
  logic             exp_d;
  logic             exp_rst;
  logic [15:0]      remain;
  logic             exp_q;
  logic             q_bad;
  logic             qn_bad;
  logic             fail;
  logic [ERR_W-1:0] err_next;

  // The flop under test samples d/rst on the same edge we capture them, so
  // its q one edge later must equal the captured value (or 0 if reset).
  always_comb begin
    exp_q    = exp_rst ? 1'b0 : exp_d;
    q_bad    = (dut_q != exp_q);
    qn_bad   = (dut_qn == dut_q);
    fail     = q_bad || (QN_EN && qn_bad);
    err_next = (fail && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch      <= 1'b0;
      err_cnt       <= '0;
      chk_cnt       <= '0;
      first_err_idx <= '0;
      exp_d         <= 1'b0;
      exp_rst       <= 1'b0;
      remain        <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= CHECK;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            chk_cnt       <= '0;
            first_err_idx <= '0;
            exp_d         <= dut_d;
            exp_rst       <= dut_rst;
            remain        <= LAST;
          end
        end
        CHECK: begin
          mismatch <= fail;
          err_cnt  <= err_next;
          chk_cnt  <= chk_cnt + 16'd1;
          exp_d    <= dut_d;
          exp_rst  <= dut_rst;
          // err_cnt is still zero exactly until the first failure of the run
          if (fail && (err_cnt == '0)) first_err_idx <= chk_cnt;
          if (remain == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            remain <= remain - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 The module SHALL have parameter CHK_LEN, default 16, giving the number of compare cycles per run (legal 1..65535).
REQ-002 The module SHALL have parameter ERR_W, default 8, giving the width of the error counter (legal 1..16).
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-low reset for the whole block.
REQ-005 The module SHALL have port start  input  1  begins a run when sampled high in IDLE or DONE.
REQ-006 The module SHALL have port dut_rst  input  1  synchronous active-high reset being applied to the flip-flop under test.
REQ-007 The module SHALL have port dut_d  input  1  data being applied to the flip-flop under test.
REQ-008 The module SHALL have port dut_q  input  1  q output of the flip-flop under test.
REQ-009 The module SHALL have port dut_qn  input  1  qn output of the flip-flop under test.
REQ-010 The module SHALL have port busy  output  1  high while in CHECK.
REQ-011 The module SHALL have port done  output  1  high while in DONE.
REQ-012 The module SHALL have port pass  output  1  high while in DONE with err_cnt == 0.
REQ-013 The module SHALL have port mismatch  output  1  registered one-cycle pulse per failing compare.
REQ-014 The module SHALL have port err_cnt  output  ERR_W  failing-compare count, saturating at all-ones.
REQ-015 The module SHALL have port chk_cnt  output  16  completed compares in the current run.
REQ-016 The module SHALL have port first_err_idx  output  16  chk_cnt value at the first failing compare; 0 if none.

Function
REQ-017 The FSM SHALL have states IDLE, CHECK and DONE: IDLE -start-> CHECK; CHECK -CHK_LEN-th compare-> DONE; DONE -start-> CHECK; start SHALL be ignored in CHECK.
REQ-018 On every edge that enters CHECK, the block SHALL clear err_cnt, chk_cnt and first_err_idx and capture dut_d and dut_rst into the expected-value register, with no compare on that edge.
REQ-019 On each edge in CHECK, exp_q SHALL be 0 if the captured dut_rst was 1, else the captured dut_d; the block SHALL compare dut_q with exp_q, increment chk_cnt, and recapture dut_d and dut_rst.
REQ-020 Latency: with start sampled at edge t, compares SHALL occur at edges t+1..t+CHK_LEN, and done SHALL be high after edge t+CHK_LEN.
REQ-021 A failing compare SHALL raise mismatch for exactly the following cycle and increment err_cnt unless err_cnt is all-ones; err_cnt SHALL hold at all-ones once there.
REQ-022 first_err_idx SHALL be loaded only on the first failing compare of a run.
REQ-023 A failure on the final compare SHALL be counted before DONE is entered, so that pass is 0.
REQ-024 With CHK_LEN=1, the block SHALL perform exactly one compare and enter DONE one edge after start.
REQ-025 In DONE, the counters SHALL hold their values until the next start.

Reset
REQ-026 reset low SHALL immediately force state IDLE, with busy, done, pass, mismatch, err_cnt, chk_cnt, first_err_idx and the expected-value register all 0, independent of clk.
REQ-027 Assertion of reset mid-run SHALL abandon the run; a new start SHALL be required after release.

Configuration
REQ-028 With macro DFF_CHK_QN_EN defined, each compare SHALL also fail if dut_qn != ~dut_q, counting at most one error per compare even when both checks fail.
REQ-029 With DFF_CHK_QN_EN undefined, dut_qn SHALL be ignored and only dut_q SHALL be checked.

Verification
REQ-030 Correct DUT, CHK_LEN=4, dut_d=1,0,1,1, dut_rst=0, start at edge 0 -> done high after edge 4, err_cnt=0, pass=1, chk_cnt=4.
REQ-031 dut_q stuck at 0, dut_d=1 constant, CHK_LEN=4 -> err_cnt=4, first_err_idx=0, mismatch high 4 cycles, pass=0.
REQ-032 dut_d=1 with dut_rst=1 for one cycle; a DUT that ignores reset -> err_cnt=1 at that index; a correct DUT -> err_cnt=0.
REQ-033 reset driven low between edges mid-CHECK -> all outputs 0 before the next edge; after release, start is needed to run.
REQ-034 dut_qn tied equal to dut_q, correct q, CHK_LEN=8 -> err_cnt=8 with DFF_CHK_QN_EN defined, err_cnt=0 without it.
REQ-035 ERR_W=2, 6 failing compares out of CHK_LEN=6 -> err_cnt=3 (saturated), mismatch pulses=6, pass=0.
